ham8b_serial_tx: RTL and testbench
==================================

# ham8b_serial_tx

- Serial transmitter for the Hamming(12,8) code used by the team's single-error corrector.
- Accepts a data byte on a valid/ready handshake and encodes it into a 12-bit even-parity codeword, with optional single-bit error injection.
- Shifts the codeword out on a one-wire line framed by a start and a stop bit.
- Sits upstream of the corrector; `COD` can be looped directly into the corrector in benches.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `DATA` in 8: byte to send; D1..D8 = `DATA[7]`..`DATA[0]`.
- `DATA_VALID` in 1: `DATA`/`ERR_POS` valid.
- `DATA_READY` out 1: transmitter can accept a byte.
- `ERR_POS` in 4: codeword position (1..12) to flip; 0 or 13..15 means no injection.
- `TX` out 1: serial line; idles high.
- `TX_ACTIVE` out 1: high while a frame is on the line (START..STOP).
- `COD` out 12: codeword as transmitted, including any injected flip.
- `DONE` out 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
Codeword layout, position p maps to `COD[12-p]`:
- `COD[11:0]` = P1 P2 D1 P3 D2 D3 D4 P4 D5 D6 D7 D8.

Parity equations (even parity):
- P1 = D1^D2^D4^D5^D7
- P2 = D1^D3^D4^D6^D7
- P3 = D2^D3^D4^D8
- P4 = D5^D6^D7^D8

Handshake:
- A transfer occurs when `DATA_VALID && DATA_READY`.
- On transfer, `COD` is loaded with the encoded word. If `ERR_POS` is in 1..12, bit `COD[12-ERR_POS]` is inverted.
- `DATA_READY` = (state == IDLE). `DATA_VALID` outside IDLE is ignored.

States:
- IDLE: `TX`=1. On transfer, go to START.
- START: `TX`=0 for `CLKS_PER_BIT` cycles, then go to SHIFT with bit index 0.
- SHIFT: `TX`=`COD[11-idx]` (position 1 first) for `CLKS_PER_BIT` cycles per bit. After idx 11, go to STOP.
- STOP: `TX`=1 for `CLKS_PER_BIT` cycles. `DONE`=1 in the final cycle, then go to IDLE.

Counters:
- Cycle counter 8 bits; it rolls over to 0 at `CLKS_PER_BIT-1`.
- Bit index 4 bits, 0..11.

Reset values:
- `TX`=1, `TX_ACTIVE`=0, `DONE`=0, `COD`=0, `DATA_READY`=1, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). `TX` returns high, and no `DONE` is generated.

## Timing
- All outputs except `DATA_READY` are registered. `DATA_READY` is decoded from the state register.
- Transfer in cycle t: START (`TX`=0, `TX_ACTIVE`=1) is visible from cycle t+1.
- `COD` is valid from t+1 and stable until the next transfer.
- Frame length is 14·`CLKS_PER_BIT` cycles, t+1 through t+14·`CLKS_PER_BIT`.
- `DONE` is asserted in cycle t+14·`CLKS_PER_BIT`. `DATA_READY` rises the following cycle.
- Back-to-back frames are separated by at least one IDLE cycle with `TX`=1.
- With `CLKS_PER_BIT`=1, every state holds exactly one cycle per bit. No extra cycles are allowed.

## Structure
- Shared package/include `ham8b_pkg`:
  - position constants for P1..P4 and D1..D8 within `COD`
  - the four parity equations as a function
  - state encodings (IDLE=0, START=1, SHIFT=2, STOP=3)
- The corrector and this transmitter share `ham8b_pkg` so the bit map is defined once.
- One sub-module: `ham8b_encoder`, purely combinational, `DATA[7:0]` -> `CODE[11:0]`.
- Error injection, FSM and shifter stay in `ham8b_serial_tx`.

## Test plan
- Reset, then release: `TX`=1, `DATA_READY`=1, `TX_ACTIVE`=0, `COD`=0x000.
  - Assert `rst_n` low mid-SHIFT: `TX`=1 immediately, and `DONE` never pulses.
- `CLKS_PER_BIT`=1, `DATA`=0xA5, `ERR_POS`=0:
  - `COD`=0xE45.
  - `TX` from t+1 = 0,1,1,1,0,0,1,0,0,0,1,0,1,1.
  - `DONE` at t+14, `DATA_READY` at t+15.
- `DATA`=0x00 -> `COD`=0x000. `DATA`=0xFF -> `COD`=0xEEF.
- `DATA`=0xA5, `ERR_POS`=5 -> `COD`=0xEC5. Fed to the corrector, it returns 0xE45.
  - `ERR_POS`=13 -> `COD`=0xE45, no flip.
- `CLKS_PER_BIT`=4:
  - Hold `DATA_VALID`=1 with changing `DATA` during the frame: only the first byte is sent.
  - Frame length is 56 cycles.
  - The second byte starts after exactly one IDLE cycle.
- Randomized 256 bytes × ERR_POS 0..12, looped through the corrector.
  - Required: the corrected codeword always equals the clean encoding of `DATA`.

Source files
------------

// File: rtl/ham8b_pkg.sv
// ham8b_pkg
// Shared definitions for the Hamming(12,8) transmitter and corrector.
//   - bit positions of P1..P4 and D1..D8 within the 12-bit codeword
//     (codeword position p sits at COD[12-p], position 1 is the MSB)
//   - the four even-parity equations
//   - transmitter state encoding
package ham8b_pkg;

    localparam int COD_W  = 12;

    localparam int POS_P1 = 11;
    localparam int POS_P2 = 10;
    localparam int POS_D1 = 9;
    localparam int POS_P3 = 8;
    localparam int POS_D2 = 7;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 5;
    localparam int POS_P4 = 4;
    localparam int POS_D5 = 3;
    localparam int POS_D6 = 2;
    localparam int POS_D7 = 1;
    localparam int POS_D8 = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Returns {P1, P2, P3, P4} for a data byte where D1 = d[7] ... D8 = d[0].
    function automatic logic [3:0] ham8b_parity(input logic [7:0] d);
        logic d1, d2, d3, d4, d5, d6, d7, d8;
        d1 = d[7];
        d2 = d[6];
        d3 = d[5];
        d4 = d[4];
        d5 = d[3];
        d6 = d[2];
        d7 = d[1];
        d8 = d[0];
        return {d1 ^ d2 ^ d4 ^ d5 ^ d7,
                d1 ^ d3 ^ d4 ^ d6 ^ d7,
                d2 ^ d3 ^ d4 ^ d8,
                d5 ^ d6 ^ d7 ^ d8};
    endfunction

endpackage

// File: rtl/ham8b_encoder.sv
// ham8b_encoder
// Purely combinational Hamming(12,8) encoder.
// Ports:
//   DATA [7:0]  in   data byte, D1 = DATA[7] ... D8 = DATA[0]
//   CODE [11:0] out  codeword P1 P2 D1 P3 D2 D3 D4 P4 D5 D6 D7 D8 (MSB first)
module ham8b_encoder (
    input  logic [7:0]  DATA,
    output logic [11:0] CODE
);
    import ham8b_pkg::*;

    logic [3:0] par;

    always_comb begin
        par          = ham8b_parity(DATA);
        CODE         = '0;
        CODE[POS_P1] = par[3];
        CODE[POS_P2] = par[2];
        CODE[POS_P3] = par[1];
        CODE[POS_P4] = par[0];
        CODE[POS_D1] = DATA[7];
        CODE[POS_D2] = DATA[6];
        CODE[POS_D3] = DATA[5];
        CODE[POS_D4] = DATA[4];
        CODE[POS_D5] = DATA[3];
        CODE[POS_D6] = DATA[2];
        CODE[POS_D7] = DATA[1];
        CODE[POS_D8] = DATA[0];
    end

endmodule

// File: rtl/ham8b_serial_tx.sv
// ham8b_serial_tx
// Serial transmitter for Hamming(12,8) codewords with optional single-bit
// error injection. A frame is START(0), 12 codeword bits (position 1 first),
// STOP(1), each bit lasting CLKS_PER_BIT cycles.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   DATA [7:0]  in   byte to send
//   DATA_VALID  in   DATA/ERR_POS valid
//   DATA_READY  out  transmitter idle, byte accepted on DATA_VALID
//   ERR_POS [3:0] in codeword position 1..12 to invert, other values: none
//   TX          out  serial line, idles high
//   TX_ACTIVE   out  high for the whole frame
//   COD [11:0]  out  codeword as transmitted (including injected flip)
//   DONE        out  one-cycle pulse in the last cycle of the stop bit
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line high, waiting for a byte
// ST_START | start bit (TX=0)
// ST_SHIFT | codeword bit idx on the line, COD[11-idx]
// ST_STOP  | stop bit (TX=1), DONE in its final cycle
module ham8b_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  DATA,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    input  logic [3:0]  ERR_POS,
    output logic        TX,
    output logic        TX_ACTIVE,
    output logic [11:0] COD,
    output logic        DONE
);
    import ham8b_pkg::*;

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] IDX_LAST = 4'd11;

    tx_state_t   state;
    logic [7:0]  cnt;
    logic [3:0]  idx;
    logic [11:0] enc_code;
    logic [11:0] err_mask;
    logic        xfer;

    ham8b_encoder u_enc (
        .DATA (DATA),
        .CODE (enc_code)
    );

    // Position p lives at COD[12-p], so position 1 is 12'h800.
    always_comb begin
        err_mask = '0;
        if (ERR_POS >= 4'd1 && ERR_POS <= 4'd12)
            err_mask = 12'h800 >> (ERR_POS - 4'd1);
    end

    assign DATA_READY = (state == ST_IDLE);
    assign xfer       = DATA_VALID && DATA_READY;

    // TX/TX_ACTIVE/DONE are loaded with the value they must hold in the
    // state being entered, so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            TX        <= 1'b1;
            TX_ACTIVE <= 1'b0;
            DONE      <= 1'b0;
            COD       <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        state     <= ST_START;
                        cnt       <= '0;
                        COD       <= enc_code ^ err_mask;
                        TX        <= 1'b0;
                        TX_ACTIVE <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_SHIFT;
                        TX    <= COD[11];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_STOP;
                            TX    <= 1'b1;
                            // a one-cycle stop bit is its own final cycle
                            DONE  <= (CNT_LAST == 8'd0);
                        end else begin
                            idx <= idx + 4'd1;
                            TX  <= COD[4'd10 - idx];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        state     <= ST_IDLE;
                        TX_ACTIVE <= 1'b0;
                    end else begin
                        cnt  <= cnt + 8'd1;
                        DONE <= (cnt + 8'd1 == CNT_LAST);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ham8b_serial_tx.sv
module tb_ham8b_serial_tx;

    localparam int C0 = 1;
    localparam int C1 = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data  [2];
    logic        valid [2];
    logic [3:0]  errp  [2];
    logic        ready [2];
    logic        tx    [2];
    logic        act   [2];
    logic        done  [2];
    logic [11:0] cod   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int          fstart [2] = '{-1, -1};
    logic [11:0] mcod   [2] = '{12'h000, 12'h000};
    int          xfers  [2] = '{0, 0};

    always #5 clk = ~clk;

    ham8b_serial_tx #(.CLKS_PER_BIT(C0)) dut0 (
        .clk(clk), .rst_n(rst_n), .DATA(data[0]), .DATA_VALID(valid[0]),
        .DATA_READY(ready[0]), .ERR_POS(errp[0]), .TX(tx[0]),
        .TX_ACTIVE(act[0]), .COD(cod[0]), .DONE(done[0])
    );

    ham8b_serial_tx #(.CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .rst_n(rst_n), .DATA(data[1]), .DATA_VALID(valid[1]),
        .DATA_READY(ready[1]), .ERR_POS(errp[1]), .TX(tx[1]),
        .TX_ACTIVE(act[1]), .COD(cod[1]), .DONE(done[1])
    );

    function automatic int cpb(input int i);
        return (i == 0) ? C0 : C1;
    endfunction

    // Classic Hamming construction: data in non-power-of-two positions,
    // parity at position 2^j covers every position whose index has bit j set.
    function automatic logic [11:0] ref_encode(input logic [7:0] d);
        int          dpos [8];
        logic [12:0] w;
        logic [11:0] c;
        int          pp;
        logic        par;
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        w = '0;
        for (int k = 0; k < 8; k++) w[dpos[k]] = d[7-k];
        for (int j = 0; j < 4; j++) begin
            pp  = 1 << j;
            par = 1'b0;
            for (int p = 1; p <= 12; p++)
                if ((p & pp) != 0 && p != pp) par = par ^ w[p];
            w[pp] = par;
        end
        for (int p = 1; p <= 12; p++) c[12-p] = w[p];
        return c;
    endfunction

    function automatic logic [11:0] inject(input logic [11:0] c, input logic [3:0] e);
        int p;
        p = int'(e);
        if (p >= 1 && p <= 12) c[12-p] = ~c[12-p];
        return c;
    endfunction

    // Syndrome = XOR of the positions of all set bits; nonzero names the bad bit.
    function automatic logic [11:0] correct(input logic [11:0] c);
        int syn;
        syn = 0;
        for (int p = 1; p <= 12; p++) if (c[12-p]) syn = syn ^ p;
        if (syn >= 1 && syn <= 12) c[12-syn] = ~c[12-syn];
        return c;
    endfunction

    // Frame bit b: 0 = start, 1..12 = codeword positions, 13 = stop.
    function automatic logic frame_bit(input logic [11:0] c, input int b);
        if (b == 0) return 1'b0;
        if (b >= 13) return 1'b1;
        return c[12-b];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    // Reference model: remembers when each instance accepted a byte and what
    // codeword it must carry. cyc is the cycle that ends at this edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                fstart[i] = -1;
                mcod[i]   = '0;
            end else if (valid[i] === 1'b1 &&
                         (fstart[i] < 0 || cyc - fstart[i] > 14 * cpb(i))) begin
                fstart[i] = cyc;
                mcod[i]   = inject(ref_encode(data[i]), errp[i]);
                xfers[i]  = xfers[i] + 1;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int   k;
            int   c;
            logic inf;
            logic etx;
            if (!rst_n) begin
                chk($sformatf("rst_tx%0d", i),    32'(tx[i]),    32'd1);
                chk($sformatf("rst_act%0d", i),   32'(act[i]),   32'd0);
                chk($sformatf("rst_done%0d", i),  32'(done[i]),  32'd0);
                chk($sformatf("rst_cod%0d", i),   32'(cod[i]),   32'd0);
                chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
            end else begin
                c   = cpb(i);
                k   = cyc - fstart[i];
                inf = (fstart[i] >= 0) && (k >= 1) && (k <= 14 * c);
                etx = inf ? frame_bit(mcod[i], (k - 1) / c) : 1'b1;
                chk($sformatf("tx%0d", i),    32'(tx[i]),    32'(etx));
                chk($sformatf("act%0d", i),   32'(act[i]),   32'(inf));
                chk($sformatf("done%0d", i),  32'(done[i]),  32'(inf && k == 14 * c));
                chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(!inf));
                chk($sformatf("cod%0d", i),   32'(cod[i]),   32'(mcod[i]));
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input logic [3:0] e);
        int n0;
        n0       = xfers[i];
        data[i]  = d;
        errp[i]  = e;
        valid[i] = 1'b1;
        for (int b = 0; b < 500 && xfers[i] == n0; b++) begin
            @(posedge clk);
            #1;
        end
        chk("xfer_accepted", 32'(xfers[i] != n0), 32'd1);
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        for (int b = 0; b < 500 && fstart[i] >= 0 && cyc - fstart[i] <= 14 * cpb(i); b++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_reached", 32'(fstart[i] < 0 || cyc - fstart[i] > 14 * cpb(i)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        txs [17];
        logic        dns [17];
        logic        rds [17];
        logic [13:0] exp_seq;
        logic        a [140];
        logic [11:0] cod_done;
        logic        got_done;
        int          r1, f1, r2, nd;
        logic [7:0]  d;

        for (int i = 0; i < 2; i++) begin
            data[i]  = '0;
            valid[i] = 1'b0;
            errp[i]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // reset state after release
        chk("init_tx",    32'(tx[0]),    32'd1);
        chk("init_ready", 32'(ready[0]), 32'd1);
        chk("init_act",   32'(act[0]),   32'd0);
        chk("init_cod",   32'(cod[0]),   32'h000);
        chk("init_cod1",  32'(cod[1]),   32'h000);

        // pin the model with hand-derived codewords
        chk("model_a5",   32'(ref_encode(8'hA5)), 32'hE45);
        chk("model_ff",   32'(ref_encode(8'hFF)), 32'hEEF);
        chk("model_inj5", 32'(inject(ref_encode(8'hA5), 4'd5)), 32'hEC5);
        chk("model_corr", 32'(correct(12'hEC5)), 32'hE45);

        // CLKS_PER_BIT=1, 0xA5, no injection: exact line sequence
        send(0, 8'hA5, 4'd0);
        chk("cod_a5", 32'(cod[0]), 32'hE45);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            txs[k] = tx[0];
            dns[k] = done[0];
            rds[k] = ready[0];
        end
        exp_seq = 14'b01110010001011;
        for (int k = 1; k <= 14; k++)
            chk($sformatf("seq_a5_k%0d", k), 32'(txs[k]), 32'(exp_seq[14-k]));
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("done_k%0d", k),  32'(dns[k]), 32'(k == 14));
            chk($sformatf("ready_k%0d", k), 32'(rds[k]), 32'(k >= 15));
        end

        send(0, 8'h00, 4'd0);
        chk("cod_00", 32'(cod[0]), 32'h000);
        send(0, 8'hFF, 4'd0);
        chk("cod_ff", 32'(cod[0]), 32'hEEF);
        send(0, 8'hA5, 4'd5);
        chk("cod_a5_e5", 32'(cod[0]), 32'hEC5);
        chk("corr_a5_e5", 32'(correct(cod[0])), 32'hE45);
        send(0, 8'hA5, 4'd13);
        chk("cod_a5_e13", 32'(cod[0]), 32'hE45);
        wait_idle(0);

        // CLKS_PER_BIT=4: valid held high while DATA keeps changing
        got_done = 1'b0;
        cod_done = '0;
        data[1]  = 8'hA5;
        errp[1]  = 4'd0;
        valid[1] = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            a[c] = act[1];
            if (done[1] && !got_done) begin
                cod_done = cod[1];
                got_done = 1'b1;
            end
            @(posedge clk);
            #1 data[1] = 8'($urandom);
        end
        valid[1] = 1'b0;
        r1 = -1; f1 = -1; r2 = -1;
        for (int c = 0; c < 130; c++) begin
            if (r1 < 0 && a[c]) r1 = c;
            else if (r1 >= 0 && f1 < 0 && !a[c]) f1 = c;
            else if (f1 >= 0 && r2 < 0 && a[c]) r2 = c;
        end
        chk("frame_len_56", 32'(f1 - r1), 32'd56);
        chk("idle_gap_1",   32'(r2 - f1), 32'd1);
        chk("done_seen",    32'(got_done), 32'd1);
        chk("first_byte",   32'(cod_done), 32'hE45);
        wait_idle(1);

        // asynchronous reset in the middle of SHIFT
        send(1, 8'h00, 4'd0);
        repeat (4 * C1 + 8) @(posedge clk);
        #3;
        chk("pre_rst_tx", 32'(tx[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx",    32'(tx[1]),    32'd1);
        chk("abort_act",   32'(act[1]),   32'd0);
        chk("abort_ready", 32'(ready[1]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        repeat (80) begin
            @(negedge clk);
            if (done[1]) nd++;
        end
        chk("no_done_after_abort", 32'(nd), 32'd0);

        // random bytes with every ERR_POS value, through the corrector model
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            send(0, d, 4'(n % 16));
            chk("corrected", 32'(correct(cod[0])), 32'(ref_encode(d)));
        end
        wait_idle(0);
        wait_idle(1);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
